rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (regwrite/rd/wd, written on posedge clk) between two sources: the in-order pipeline WB stage and the long-latency multi-cycle unit (mul/div).
- Pipeline WB has fixed priority. Multi-cycle results are parked in a 1-entry holding register.
- A starvation counter forces a pipeline WB bubble when a parked result waits too long.
- A pending-destination scoreboard feeds the ID-stage hazard unit.

Parameters:
- XLEN, 32, data width
- AW, 5, register index width
- NREG, 32, number of architectural registers (2**AW)
- STARVE_MAX, 3, consecutive lost cycles before pipe_stall is asserted (1..15)

Ports:
- clk  in  1  clock, posedge
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  WB stage write request
- pipe_rd  in  AW  WB destination
- pipe_wd  in  XLEN  WB data
- mc_issue  in  1  multi-cycle op issued this cycle
- mc_issue_rd  in  AW  destination of the issued op
- mc_valid  in  1  multi-cycle result valid
- mc_rd  in  AW  result destination
- mc_wd  in  XLEN  result data
- mc_ready  out  1  holding register can accept
- rf_regwrite  out  1  to register file regwrite
- rf_rd  out  AW  to register file rd
- rf_wd  out  XLEN  to register file wd
- pipe_stall  out  1  pipeline must present pipe_we=0 next cycle
- chk_rs1  in  AW  ID source 1
- chk_rs2  in  AW  ID source 2
- chk_rd  in  AW  ID destination
- hazard  out  1  any checked register is pending
- pending  out  NREG  scoreboard vector

Behaviour:
- Reset (async, rst_n=0):
  - hold_valid=0, starve_cnt=0, pending=0, pipe_stall=0.
  - Consequently mc_ready=1, rf_regwrite=0, hazard=0.
  - Reset mid-operation discards any parked result.
- Capture handshake:
  - mc_ready = !hold_valid.
  - On posedge with mc_valid && mc_ready: the hold register loads {mc_rd, mc_wd}.
  - If mc_rd==0 the result is accepted but not loaded (hold_valid stays 0).
- Write-port mux (combinational, same cycle):
  - pipe_win = pipe_we && pipe_rd!=0.
  - If pipe_win: rf_* = pipe_* with rf_regwrite=1.
  - Else if hold_valid: rf_* = hold_*, rf_regwrite=1, and hold_valid clears at posedge.
  - Else rf_regwrite=0 and rf_rd/rf_wd = 0.
  - Minimum latency from mc accept to RF write is 1 cycle.
- Simultaneous hold drain and new capture: mc_ready is already 0 while hold_valid=1, so a new result is accepted only in the cycle after the drain.
- Starvation counter:
  - starve_cnt increments (saturating) on each cycle with hold_valid && pipe_win.
  - It clears when hold drains.
  - pipe_stall is registered: 1 in the cycle after starve_cnt reaches STARVE_MAX, held until the drain cycle, 0 the cycle after.
- Stall violation: if pipe_we=1 while pipe_stall=1, the pipeline still wins. This is a protocol violation and the requester must avoid it.
- Scoreboard:
  - pending[r] sets on mc_issue with mc_issue_rd=r≠0.
  - pending[r] clears on the cycle hold (or bypass) writes r.
  - Same-cycle clear and set of the same r leaves pending[r]=1.
  - pending[0] is always 0.
  - hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd], purely combinational.
  - Issuing to an already pending register is illegal; the ID stage prevents it via hazard.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: when mc_valid && mc_ready && !pipe_win && !hold_valid, the result goes straight to rf_* that cycle. The hold register is not loaded, and pending clears at that posedge (0-cycle latency).
- Undefined: every result passes through the hold register (latency ≥1).

Decomposition:
- Package rf_pkg: XLEN, AW, NREG constants; typedef reg_idx_t [AW-1:0]; typedef xword_t [XLEN-1:0].
- Sub-module rf_scoreboard: pending vector with set/clear ports and the 3-read hazard lookup. The arbiter instantiates it once.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release → mc_ready=1, pending=0, rf_regwrite=0, pipe_stall=0.
- Idle drain: mc_issue rd=7 at t0 → pending[7]=1, hazard=1 for chk_rs1=7.
  - mc_valid rd=7 wd=CAFEBABE at t2 with pipe_we=0 → rf write x7=CAFEBABE at t3, pending[7]=0 after.
  - With RF_WB_BYPASS_EN: the write occurs at t2.
- Priority: hold holds x5=12345678 while pipe_we=1 x4=DEADBEEF → pipe writes x4 that cycle; hold drains in the first cycle with pipe_we=0.
- Starvation: STARVE_MAX=3, hold valid, pipe_we=1 every cycle → pipe_stall rises after the 3rd lost cycle. The bench then drives pipe_we=0, hold writes, and pipe_stall drops the next cycle.
- x0 handling: mc_valid rd=0 → accepted, no RF write, hold stays empty. pipe_we rd=0 with hold valid → hold wins the port.
- Async reset mid-op: assert rst_n low between edges with hold_valid=1, pending[9]=1 → immediately hold_valid=0, pending=0, rf_regwrite=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Optional feature macro used by the arbiter: RF_WB_BYPASS_EN.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

    // Width of the starvation counter; it saturates at all-ones.
    localparam int SCW = 4;

    function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
        if (v == {SCW{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register,
// set when a multi-cycle op issues, cleared when its result is written.
module rf_scoreboard #(
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    output logic            hazard,
    output logic [NREG-1:0] pending
);

    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;

    // x0 never becomes pending; for the others a set wins over a same-cycle clear
    assign pending_next[0] = 1'b0;
    for (genvar gi = 1; gi < NREG; gi++) begin : g_bit
        assign pending_next[gi] = (set_en && set_idx == AW'(gi)) ? 1'b1 :
                                  (clr_en && clr_idx == AW'(gi)) ? 1'b0 :
                                  pending_reg[gi];
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;
    assign hazard  = pending_reg[rs1] | pending_reg[rs2] | pending_reg[rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has fixed priority, the
// multi-cycle unit's result waits in a 1-entry holding register, and a
// starvation counter requests a WB bubble when that result waits too long.
// Optional macro RF_WB_BYPASS_EN: an accepted result that meets an idle
// write port is written in the same cycle instead of being parked.
module rf_wb_arbiter #(
    parameter int XLEN       = rf_pkg::XLEN,
    parameter int AW         = rf_pkg::AW,
    parameter int NREG       = rf_pkg::NREG,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_rd,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            mc_issue,
    input  logic [AW-1:0]   mc_issue_rd,
    input  logic            mc_valid,
    input  logic [AW-1:0]   mc_rd,
    input  logic [XLEN-1:0] mc_wd,
    output logic            mc_ready,
    output logic            rf_regwrite,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wd,
    output logic            pipe_stall,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    input  logic [AW-1:0]   chk_rd,
    output logic            hazard,
    output logic [NREG-1:0] pending
);

    import rf_pkg::*;

    logic            hold_valid_reg;
    logic [AW-1:0]   hold_rd_reg;
    logic [XLEN-1:0] hold_wd_reg;
    logic [SCW-1:0]  starve_cnt_reg;
    logic [SCW-1:0]  starve_cnt_next;
    logic            pipe_stall_reg;
    logic            pipe_stall_next;

    logic pipe_win;
    logic accept;
    logic bypass;
    logic drain;
    logic load;

    // Writes to x0 are meaningless, so they never claim the port
    assign pipe_win = pipe_we && (pipe_rd != '0);
    assign mc_ready = !hold_valid_reg;
    assign accept   = mc_valid && mc_ready;
    assign drain    = hold_valid_reg && !pipe_win;

`ifdef RF_WB_BYPASS_EN
    // accept already implies the holding register is empty
    assign bypass = accept && !pipe_win && (mc_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // Results for x0 are consumed without occupying the holding register
    assign load = accept && (mc_rd != '0) && !bypass;

    // Write-port mux: pipeline first, then parked result, then bypass
    always_comb begin
        rf_regwrite = 1'b0;
        rf_rd       = '0;
        rf_wd       = '0;
        if (pipe_win) begin
            rf_regwrite = 1'b1;
            rf_rd       = pipe_rd;
            rf_wd       = pipe_wd;
        end else if (hold_valid_reg) begin
            rf_regwrite = 1'b1;
            rf_rd       = hold_rd_reg;
            rf_wd       = hold_wd_reg;
        end else if (bypass) begin
            rf_regwrite = 1'b1;
            rf_rd       = mc_rd;
            rf_wd       = mc_wd;
        end
    end

    // Holding register: drains when it wins the port, loads when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_reg <= 1'b0;
            hold_rd_reg    <= '0;
            hold_wd_reg    <= '0;
        end else if (drain) begin
            hold_valid_reg <= 1'b0;
        end else if (load) begin
            hold_valid_reg <= 1'b1;
            hold_rd_reg    <= mc_rd;
            hold_wd_reg    <= mc_wd;
        end
    end

    // Starvation count of cycles the parked result lost to the pipeline
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (drain) begin
            starve_cnt_next = '0;
        end else if (hold_valid_reg && pipe_win) begin
            starve_cnt_next = sat_inc(starve_cnt_reg);
        end
        pipe_stall_next = (starve_cnt_next >= SCW'(STARVE_MAX));
    end

    // Starvation counter and registered bubble request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
            pipe_stall_reg <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            pipe_stall_reg <= pipe_stall_next;
        end
    end

    assign pipe_stall = pipe_stall_reg;

    rf_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (mc_issue && (mc_issue_rd != '0)),
        .set_idx (mc_issue_rd),
        .clr_en  (drain || bypass),
        .clr_idx (rf_rd),
        .rs1     (chk_rs1),
        .rs2     (chk_rs2),
        .rd      (chk_rd),
        .hazard  (hazard),
        .pending (pending)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_rf_wb_arbiter;

    import rf_pkg::*;

    localparam int STARVE_MAX = 3;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      pipe_we = 1'b0;
    reg_idx_t  pipe_rd = '0;
    xword_t    pipe_wd = '0;
    logic      mc_issue = 1'b0;
    reg_idx_t  mc_issue_rd = '0;
    logic      mc_valid = 1'b0;
    reg_idx_t  mc_rd = '0;
    xword_t    mc_wd = '0;
    logic      mc_ready;
    logic      rf_regwrite;
    reg_idx_t  rf_rd;
    xword_t    rf_wd;
    logic      pipe_stall;
    reg_idx_t  chk_rs1 = '0;
    reg_idx_t  chk_rs2 = '0;
    reg_idx_t  chk_rd = '0;
    logic      hazard;
    logic [NREG-1:0] pending;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_wd(mc_wd), .mc_ready(mc_ready),
        .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .pipe_stall(pipe_stall),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .pending(pending)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { reg_idx_t rd; xword_t wd; } res_t;
    res_t            hold_q[$];
    bit [NREG-1:0]   pend_m;
    int              starve_m;
    bit              stall_m;
    int              src_m;      // 0 none, 1 pipe, 2 parked, 3 bypass
    logic            m_we, m_rdy, m_hz;
    reg_idx_t        m_rd;
    xword_t          m_wd;

    task automatic model_reset();
        hold_q.delete();
        pend_m   = '0;
        starve_m = 0;
        stall_m  = 1'b0;
    endtask

    task automatic model_eval();
        m_rdy = (hold_q.size() == 0);
        src_m = 0;
        m_we  = 1'b0;
        m_rd  = '0;
        m_wd  = '0;
        if (pipe_we && pipe_rd != 0) begin
            src_m = 1; m_we = 1'b1; m_rd = pipe_rd; m_wd = pipe_wd;
        end else if (hold_q.size() > 0) begin
            src_m = 2; m_we = 1'b1; m_rd = hold_q[0].rd; m_wd = hold_q[0].wd;
        end else if (BYP && mc_valid && mc_rd != 0) begin
            src_m = 3; m_we = 1'b1; m_rd = mc_rd; m_wd = mc_wd;
        end
        m_hz = pend_m[chk_rs1] | pend_m[chk_rs2] | pend_m[chk_rd];
    endtask

    task automatic model_commit();
        bit had_hold;
        res_t r;
        had_hold = (hold_q.size() > 0);
        if (src_m == 2 || src_m == 3) pend_m[m_rd] = 1'b0;
        if (src_m == 2) void'(hold_q.pop_front());
        if (m_rdy && mc_valid && mc_rd != 0 && src_m != 3) begin
            r.rd = mc_rd; r.wd = mc_wd;
            hold_q.push_back(r);
        end
        if (mc_issue && mc_issue_rd != 0) pend_m[mc_issue_rd] = 1'b1;
        if (src_m == 2) begin
            starve_m = 0;
            stall_m  = 1'b0;
        end else if (had_hold && src_m == 1) begin
            starve_m = (starve_m < 15) ? starve_m + 1 : 15;
            stall_m  = (starve_m >= STARVE_MAX);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic pwe; reg_idx_t prd; xword_t pwd;
        logic iss; reg_idx_t ird;
        logic mv;  reg_idx_t mrd; xword_t mwd;
        reg_idx_t chk;
        logic e_we; reg_idx_t e_rd; xword_t e_wd;
        logic e_rdy; logic e_stall; logic e_hz;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // idle drain
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b1,5'd7, 1'b0,5'd0,32'h0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1});
`ifdef RF_WB_BYPASS_EN
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd7,32'hCAFEBABE, 5'd7, 1'b1,5'd7,32'hCAFEBABE, 1'b1,1'b0,1'b1});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
`else
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd7,32'hCAFEBABE, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b1});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd7, 1'b1,5'd7,32'hCAFEBABE, 1'b0,1'b0,1'b1});
`endif
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd7, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
        // priority: pipeline beats the parked x5 result
        tbl.push_back('{1'b1,5'd4,32'hDEADBEEF, 1'b1,5'd5, 1'b1,5'd5,32'h12345678, 5'd5, 1'b1,5'd4,32'hDEADBEEF, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,5'd4,32'hDEADBEEF, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd5, 1'b1,5'd4,32'hDEADBEEF, 1'b0,1'b0,1'b1});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd5, 1'b1,5'd5,32'h12345678, 1'b0,1'b0,1'b1});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd5, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
        // starvation: three lost cycles raise pipe_stall
        tbl.push_back('{1'b1,5'd3,32'h11111111, 1'b1,5'd6, 1'b1,5'd6,32'h66666666, 5'd6, 1'b1,5'd3,32'h11111111, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,5'd3,32'h11111111, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd6, 1'b1,5'd3,32'h11111111, 1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,5'd3,32'h11111111, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd6, 1'b1,5'd3,32'h11111111, 1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,5'd3,32'h11111111, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd6, 1'b1,5'd3,32'h11111111, 1'b0,1'b0,1'b1});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd6, 1'b1,5'd6,32'h66666666, 1'b0,1'b1,1'b1});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd6, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
        // x0 handling
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b1,5'd0,32'hAAAAAAAA, 5'd0, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd0, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,5'd4,32'h44444444, 1'b1,5'd8, 1'b1,5'd8,32'h88888888, 5'd8, 1'b1,5'd4,32'h44444444, 1'b1,1'b0,1'b0});
        tbl.push_back('{1'b1,5'd0,32'hFFFFFFFF, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd8, 1'b1,5'd8,32'h88888888, 1'b0,1'b0,1'b1});
        tbl.push_back('{1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0,32'h0, 5'd8, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0});
    end

    task automatic drive_idle();
        pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
        mc_issue = 1'b0; mc_issue_rd = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_wd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    initial begin
        model_reset();
        drive_idle();

        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mc_ready", mc_ready, 1);
        check("reset_pending", pending, 0);
        check("reset_regwrite", rf_regwrite, 0);
        check("reset_stall", pipe_stall, 0);
        check("reset_hazard", hazard, 0);
        rst_n = 1'b1;

        // directed table
        foreach (tbl[i]) begin
            pipe_we = tbl[i].pwe; pipe_rd = tbl[i].prd; pipe_wd = tbl[i].pwd;
            mc_issue = tbl[i].iss; mc_issue_rd = tbl[i].ird;
            mc_valid = tbl[i].mv; mc_rd = tbl[i].mrd; mc_wd = tbl[i].mwd;
            chk_rs1 = tbl[i].chk; chk_rs2 = '0; chk_rd = '0;
            #4;
            model_eval();
            $display("[TB] row %0d we=%b rd=%0d wd=%h ready=%b stall=%b hazard=%b",
                     i, rf_regwrite, rf_rd, rf_wd, mc_ready, pipe_stall, hazard);
            check($sformatf("row%0d_regwrite", i), rf_regwrite, tbl[i].e_we);
            check($sformatf("row%0d_rd", i), rf_rd, tbl[i].e_rd);
            check($sformatf("row%0d_wd", i), rf_wd, tbl[i].e_wd);
            check($sformatf("row%0d_ready", i), mc_ready, tbl[i].e_rdy);
            check($sformatf("row%0d_stall", i), pipe_stall, tbl[i].e_stall);
            check($sformatf("row%0d_hazard", i), hazard, tbl[i].e_hz);
            advance();
        end

        // asynchronous reset with a parked x9 result and pending[9]
        pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 32'h0BADF00D;
        mc_issue = 1'b1; mc_issue_rd = 5'd9;
        mc_valid = 1'b1; mc_rd = 5'd9; mc_wd = 32'h99999999;
        #4;
        model_eval();
        advance();
        drive_idle();
        chk_rs1 = 5'd9;
        #2;
        check("pre_async_ready", mc_ready, 0);
        check("pre_async_pend9", pending[9], 1);
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset ready=%b pending=%h we=%b stall=%b", mc_ready, pending, rf_regwrite, pipe_stall);
        check("async_ready", mc_ready, 1);
        check("async_pending", pending, 0);
        check("async_regwrite", rf_regwrite, 0);
        check("async_stall", pipe_stall, 0);
        check("async_hazard", hazard, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            pipe_we     = ($urandom_range(0, 1) == 1);
            pipe_rd     = reg_idx_t'($urandom_range(0, 7));
            pipe_wd     = $urandom;
            mc_issue    = ($urandom_range(0, 9) < 3);
            mc_issue_rd = reg_idx_t'($urandom_range(0, 15));
            mc_valid    = ($urandom_range(0, 9) < 4);
            mc_rd       = reg_idx_t'($urandom_range(0, 15));
            mc_wd       = $urandom;
            chk_rs1     = reg_idx_t'($urandom_range(0, 15));
            chk_rs2     = reg_idx_t'($urandom_range(0, 15));
            chk_rd      = reg_idx_t'($urandom_range(0, 15));
            #4;
            model_eval();
            $display("[TB] rnd %0d we=%b rd=%0d wd=%h ready=%b stall=%b hazard=%b",
                     c, rf_regwrite, rf_rd, rf_wd, mc_ready, pipe_stall, hazard);
            check("rnd_regwrite", rf_regwrite, m_we);
            check("rnd_rd", rf_rd, m_rd);
            check("rnd_wd", rf_wd, m_wd);
            check("rnd_ready", mc_ready, m_rdy);
            check("rnd_stall", pipe_stall, stall_m);
            check("rnd_hazard", hazard, m_hz);
            check("rnd_pending", pending, pend_m);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
